spe_accumulator: RTL and testbench

Summing processing element (SPE) that sits directly downstream of the partial-sum PEs (PPEs, IDs 5–9) through the depacketizer. It collects one partial sum from each of the five PPEs for every output pixel assigned to this SPE and adds the five into the pixel's membrane potential. It then applies the spike threshold and emits one spike/no-spike result per pixel, in pixel order, to the output packetizer. Membrane potentials persist across timesteps.

---
 rtl/spe_accumulator_if.sv | 26 ++
 rtl/spe_accumulator.sv | 162 ++++++++++++++++
 tb/tb_spe_accumulator.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spe_accumulator_if.sv
// Partial-sum ingress and spike-result egress bundle for the summing PE.
interface spe_accumulator_if #(
    parameter int unsigned SUM_WIDTH = 14
);
    logic                        in_valid;
    logic                        in_ready;
    logic [3:0]                  in_src;
    logic signed [SUM_WIDTH-1:0] in_psum;
    logic                        ts_done;
    logic                        out_valid;
    logic                        out_ready;
    logic [6:0]                  out_pixel;
    logic                        out_spike;
    logic                        ts_complete;
    logic                        err;

    modport master (
        output in_valid, in_src, in_psum, ts_done, out_ready,
        input  in_ready, out_valid, out_pixel, out_spike, ts_complete, err
    );

    modport slave (
        input  in_valid, in_src, in_psum, ts_done, out_ready,
        output in_ready, out_valid, out_pixel, out_spike, ts_complete, err
    );
endinterface

// File: rtl/spe_accumulator.sv
// Summing PE: gathers five PPE partial sums per pixel through a small reorder
// window, integrates them into persistent membrane potentials and emits spikes.
module spe_accumulator #(
    parameter int unsigned SPE_ID       = 0,
    parameter int unsigned SUM_WIDTH    = 14,
    parameter int unsigned MEMPOT_WIDTH = 16,
    parameter int          THRESHOLD    = 64,
    parameter int unsigned SRC_BASE     = 5,
    parameter int unsigned SLOTS        = 4,
    parameter int unsigned NUM_PIXELS   = 89
) (
    input  logic               clk,
    input  logic               rst,
    spe_accumulator_if.slave   bus
);
    localparam int unsigned NSRC   = 5;
    localparam int unsigned ACC_W  = SUM_WIDTH + 3;
    localparam int unsigned PTR_W  = $clog2(NUM_PIXELS + 1);
    localparam int unsigned SLOT_W = $clog2(SLOTS);
    localparam int unsigned SUM_W  = ((ACC_W > MEMPOT_WIDTH) ? ACC_W : MEMPOT_WIDTH) + 1;
    localparam logic signed [SUM_W-1:0] MP_MAX = SUM_W'((1 << (MEMPOT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MP_MIN = ~MP_MAX;

    if (SPE_ID > 4 || NUM_PIXELS > 128 || SLOTS < 2) begin : g_param_check
        $error("spe_accumulator: unsupported parameter set");
    end

    logic [PTR_W-1:0]              src_cnt [NSRC];
    logic [PTR_W-1:0]              retire_ptr;
    logic signed [ACC_W-1:0]       acc     [SLOTS];
    logic [NSRC-1:0]               mask    [SLOTS];
    logic signed [MEMPOT_WIDTH-1:0] mempot [NUM_PIXELS];

    logic                          src_ok;
    logic [2:0]                    src_idx;
    logic [PTR_W-1:0]              cur_cnt;
    logic [SLOT_W-1:0]             wr_slot;
    logic [SLOT_W-1:0]             rd_slot;
    logic [PTR_W-1:0]              rd_idx;
    logic                          accept;
    logic                          drop;
    logic                          fire;
    logic                          pending;
    logic signed [SUM_W-1:0]       sum_w;
    logic signed [MEMPOT_WIDTH-1:0] mp_sat;
    logic                          spike_c;

    // Window check, retire decision and saturated potential update.
    always_comb begin
        src_ok   = 1'b0;
        src_idx  = '0;
        cur_cnt  = '0;
        wr_slot  = '0;
        rd_slot  = '0;
        rd_idx   = '0;
        accept   = 1'b0;
        drop     = 1'b0;
        fire     = 1'b0;
        pending  = bus.out_valid;
        sum_w    = '0;
        mp_sat   = '0;
        spike_c  = 1'b0;
        bus.in_ready = 1'b1;

        src_ok = (bus.in_src >= 4'(SRC_BASE)) && (bus.in_src <= 4'(SRC_BASE + 4));
        if (src_ok) begin
            src_idx = 3'(bus.in_src - 4'(SRC_BASE));
            cur_cnt = src_cnt[src_idx];
        end
        if (src_ok && (PTR_W'(cur_cnt - retire_ptr) >= PTR_W'(SLOTS))) begin
            bus.in_ready = 1'b0;
        end
        accept  = bus.in_valid && bus.in_ready;
        drop    = !src_ok || (cur_cnt == PTR_W'(NUM_PIXELS));
        wr_slot = cur_cnt[SLOT_W-1:0];
        rd_slot = retire_ptr[SLOT_W-1:0];
        if (retire_ptr < PTR_W'(NUM_PIXELS)) begin
            rd_idx = retire_ptr;
        end
        fire = (&mask[rd_slot]) && (!bus.out_valid || bus.out_ready);

        for (int s = 0; s < int'(SLOTS); s++) begin
            if (|mask[s]) begin
                pending = 1'b1;
            end
        end

        sum_w = SUM_W'(mempot[rd_idx]) + SUM_W'(acc[rd_slot]);
        if (sum_w > MP_MAX) begin
            mp_sat = MEMPOT_WIDTH'(MP_MAX);
        end else if (sum_w < MP_MIN) begin
            mp_sat = MEMPOT_WIDTH'(MP_MIN);
        end else begin
            mp_sat = sum_w[MEMPOT_WIDTH-1:0];
        end
        spike_c = (mp_sat >= MEMPOT_WIDTH'(THRESHOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NSRC); k++) begin
                src_cnt[k] <= '0;
            end
            for (int s = 0; s < int'(SLOTS); s++) begin
                acc[s]  <= '0;
                mask[s] <= '0;
            end
            for (int p = 0; p < int'(NUM_PIXELS); p++) begin
                mempot[p] <= '0;
            end
            retire_ptr      <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_pixel   <= '0;
            bus.out_spike   <= 1'b0;
            bus.ts_complete <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.ts_complete <= 1'b0;
            if (bus.ts_done) begin
                // Rearm for the next timestep; potentials carry over.
                if (pending) begin
                    bus.err <= 1'b1;
                end
                for (int k = 0; k < int'(NSRC); k++) begin
                    src_cnt[k] <= '0;
                end
                for (int s = 0; s < int'(SLOTS); s++) begin
                    acc[s]  <= '0;
                    mask[s] <= '0;
                end
                retire_ptr    <= '0;
                bus.out_valid <= 1'b0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    if (bus.out_pixel == 7'(NUM_PIXELS - 1)) begin
                        bus.ts_complete <= 1'b1;
                    end
                end
                if (fire) begin
                    bus.out_valid   <= 1'b1;
                    bus.out_pixel   <= 7'(retire_ptr);
                    bus.out_spike   <= spike_c;
                    mempot[rd_idx]  <= spike_c ? '0 : mp_sat;
                    acc[rd_slot]    <= '0;
                    mask[rd_slot]   <= '0;
                    retire_ptr      <= retire_ptr + PTR_W'(1);
                end
                // The window check keeps wr_slot distinct from a retiring rd_slot.
                if (accept) begin
                    if (drop) begin
                        bus.err <= 1'b1;
                    end else begin
                        acc[wr_slot]           <= acc[wr_slot] + ACC_W'(bus.in_psum);
                        mask[wr_slot][src_idx] <= 1'b1;
                        src_cnt[src_idx]       <= cur_cnt + PTR_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spe_accumulator.sv
// Directed self-checking bench for spe_accumulator.
module tb_spe_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ts_cnt = 0;
    int   ts_cyc = -1;

    typedef struct {
        int pixel;
        int spike;
        int cyc;
    } out_t;
    out_t q[$];

    typedef struct {
        logic [4:0][3:0]         src;
        logic signed [4:0][13:0] psum;
        int                      spike1;
        int                      spike2;
    } vec_t;
    vec_t vecs[8];

    spe_accumulator_if #(.SUM_WIDTH(14)) b ();

    spe_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Handshake and completion monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (b.out_valid && b.out_ready) begin
            q.push_back('{pixel: int'(b.out_pixel), spike: int'(b.out_spike), cyc: cyc});
        end
        if (b.ts_complete) begin
            ts_cnt++;
            ts_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int src, input int psum, output int waited);
        waited = 0;
        b.in_valid = 1'b1;
        b.in_src   = 4'(src);
        b.in_psum  = 14'(psum);
        #1;
        while (!b.in_ready && waited < 100) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!b.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: src %0d never ready", src);
        end else begin
            @(posedge clk);
            #1;
        end
        b.in_valid = 1'b0;
    endtask

    task automatic send_all(input int psum);
        int w;
        for (int s = 5; s <= 9; s++) begin
            send(s, psum, w);
        end
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (q.size() < n && t < 300) begin
            tick(1);
            t++;
        end
        if (q.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_out_timeout: got %0d outputs expected %0d", q.size(), n);
        end
    endtask

    task automatic pulse_ts_done();
        b.ts_done = 1'b1;
        tick(1);
        b.ts_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        q.delete();
        ts_cnt = 0;
        ts_cyc = -1;
    endtask

    function automatic vec_t mk(input int s0, s1, s2, s3, s4,
                                input int p0, p1, p2, p3, p4,
                                input int sp1, sp2);
        vec_t v;
        v.src    = {4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
        v.psum   = {14'(p4), 14'(p3), 14'(p2), 14'(p1), 14'(p0)};
        v.spike1 = sp1;
        v.spike2 = sp2;
        return v;
    endfunction

    initial begin
        int w;
        b.in_valid  = 1'b0;
        b.in_src    = 4'd5;
        b.in_psum   = '0;
        b.ts_done   = 1'b0;
        b.out_ready = 1'b1;

        // Round 1 sums pixel-by-pixel; round 2 adds 50 to each carried potential.
        vecs[0] = mk(9, 7, 5, 8, 6,    20,   -5,   30,   10,    9, 1, 0);
        vecs[1] = mk(5, 6, 7, 8, 9,    10,   10,   10,   10,   10, 0, 1);
        vecs[2] = mk(5, 6, 7, 8, 9,    13,   13,   13,   13,   13, 1, 0);
        vecs[3] = mk(6, 5, 9, 7, 8,    12,   12,   12,   12,   15, 0, 1);
        vecs[4] = mk(8, 9, 5, 6, 7,    12,   12,   12,   12,   16, 1, 0);
        vecs[5] = mk(5, 6, 7, 8, 9, -8191,-8191,-8191,-8191,-8191, 0, 0);
        vecs[6] = mk(9, 8, 7, 6, 5,  8191, 8191, 8191, 8191, 8191, 1, 0);
        vecs[7] = mk(7, 5, 9, 6, 8,   -20,  -20,  -20,  -20,  -20, 0, 0);

        tick(2);
        check("rst_in_ready", int'(b.in_ready), 1);
        check("rst_out_valid", int'(b.out_valid), 0);
        check("rst_out_spike", int'(b.out_spike), 0);
        check("rst_out_pixel", int'(b.out_pixel), 0);
        check("rst_ts_complete", int'(b.ts_complete), 0);
        check("rst_err", int'(b.err), 0);
        rst = 1'b0;
        tick(1);

        // Table: eight pixels in one timestep, then the same pixels again.
        q.delete();
        foreach (vecs[i]) begin
            for (int j = 0; j < 5; j++) begin
                send(int'(vecs[i].src[j]), int'(vecs[i].psum[j]), w);
            end
        end
        wait_q(8);
        tick(2);
        check("ts1_count", q.size(), 8);
        foreach (vecs[i]) begin
            if (i < q.size()) begin
                check($sformatf("ts1_pixel%0d", i), q[i].pixel, i);
                check($sformatf("ts1_spike%0d", i), q[i].spike, vecs[i].spike1);
            end
        end
        pulse_ts_done();
        q.delete();
        foreach (vecs[i]) begin
            send_all(10);
        end
        wait_q(8);
        tick(2);
        check("ts2_count", q.size(), 8);
        foreach (vecs[i]) begin
            if (i < q.size()) begin
                check($sformatf("ts2_pixel%0d", i), q[i].pixel, i);
                check($sformatf("ts2_spike%0d", i), q[i].spike, vecs[i].spike2);
            end
        end

        // Reorder window: source 9 may run at most four pixels ahead.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            send(9, 1, w);
        end
        b.in_src = 4'd9;
        b.in_valid = 1'b1;
        #1;
        check("win_block", int'(b.in_ready), 0);
        tick(2);
        check("win_block_hold", int'(b.in_ready), 0);
        b.in_valid = 1'b0;
        for (int s = 5; s <= 8; s++) begin
            send(s, 1, w);
        end
        b.in_src = 4'd9;
        #1;
        check("win_before_retire", int'(b.in_ready), 0);
        tick(1);
        check("win_after_retire", int'(b.in_ready), 1);
        send(9, 1, w);
        check("win_px4_wait", w, 0);
        tick(2);
        check("win_out_count", q.size(), 1);
        if (q.size() > 0) begin
            check("win_out_pixel", q[0].pixel, 0);
            check("win_out_spike", q[0].spike, 0);
        end
        check("win_err_clear", int'(b.err), 0);
        pulse_ts_done();
        check("win_err_outstanding", int'(b.err), 1);

        // Backpressure: three complete pixels queued behind a stalled output.
        do_reset();
        b.out_ready = 1'b0;
        send_all(10);
        send_all(13);
        send_all(1);
        tick(2);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", int'(b.out_valid), 1);
            check("bp_pixel", int'(b.out_pixel), 0);
            tick(1);
        end
        check("bp_no_handshake", q.size(), 0);
        b.out_ready = 1'b1;
        wait_q(3);
        tick(3);
        check("bp_count", q.size(), 3);
        if (q.size() >= 3) begin
            check("bp_pix0", q[0].pixel, 0);
            check("bp_pix1", q[1].pixel, 1);
            check("bp_pix2", q[2].pixel, 2);
            check("bp_spk0", q[0].spike, 0);
            check("bp_spk1", q[1].spike, 1);
            check("bp_spk2", q[2].spike, 0);
            check("bp_consec1", q[1].cyc - q[0].cyc, 1);
            check("bp_consec2", q[2].cyc - q[1].cyc, 1);
        end

        // Full timestep of 89 pixels, then one stray packet.
        do_reset();
        for (int p = 0; p < 89; p++) begin
            send_all((p % 3 == 0) ? 13 : 1);
        end
        wait_q(89);
        tick(3);
        check("full_count", q.size(), 89);
        for (int p = 0; p < 89; p++) begin
            if (p < q.size()) begin
                check("full_pixel", q[p].pixel, p);
                check("full_spike", q[p].spike, (p % 3 == 0) ? 1 : 0);
            end
        end
        check("full_ts_pulses", ts_cnt, 1);
        if (q.size() == 89) begin
            check("full_ts_cycle", ts_cyc, q[88].cyc + 1);
        end
        check("full_err_clear", int'(b.err), 0);
        send(5, 1, w);
        check("full_extra_err", int'(b.err), 1);
        tick(3);
        check("full_extra_no_out", q.size(), 89);

        // Bad source, then reset mid-stream clears potentials.
        do_reset();
        send(3, 7, w);
        check("bad_src_err", int'(b.err), 1);
        send_all(10);
        wait_q(1);
        if (q.size() > 0) begin
            check("pre_rst_spike", q[0].spike, 0);
        end
        pulse_ts_done();
        q.delete();
        b.out_ready = 1'b0;
        send_all(10);
        tick(2);
        check("pre_rst_valid", int'(b.out_valid), 1);
        check("pre_rst_spike2", int'(b.out_spike), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", int'(b.out_valid), 0);
        check("rst_mid_err", int'(b.err), 0);
        tick(1);
        rst = 1'b0;
        b.out_ready = 1'b1;
        q.delete();
        tick(1);
        send_all(10);
        wait_q(1);
        if (q.size() > 0) begin
            check("post_rst_pixel", q[0].pixel, 0);
            check("post_rst_spike", q[0].spike, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
